// File: rtl/reg_file_scoreboard_pkg.sv
// Shared widths and reserved register indices for the register file and
// the destination-select logic.
package reg_file_scoreboard_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0]  count_t;

  localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
  localparam reg_idx_t REG_RA   = reg_idx_t'(31);

  // A request only touches state when it is valid and aimed at a real register.
  function automatic logic isLiveReg(input logic en, input reg_idx_t idx);
    return en && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_scoreboard_bits.sv
// Pending-write scoreboard: one busy bit per register plus a running count
// of busy registers, updated by accepted issues and by writeback clears.
module scoreboard_bits
  import reg_file_scoreboard_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_setValid,
  input  logic [ADDR_W-1:0] i_setReg,
  input  logic              i_clrValid,
  input  logic [ADDR_W-1:0] i_clrReg,
  input  logic [ADDR_W-1:0] i_queryA,
  input  logic [ADDR_W-1:0] i_queryB,
  input  logic [ADDR_W-1:0] i_queryIssue,
  output logic              o_busyA,
  output logic              o_busyB,
  output logic              o_busyIssue,
  output logic [ADDR_W:0]   o_pendingCount
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busyNext;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_countNext;
  logic                w_set;
  logic                w_clr;
  logic                w_sameReg;
  logic                w_clrWasBusy;
  logic                w_inc;
  logic                w_dec;

  // A set and a clear of the same register in one cycle leaves it busy, so
  // the count only moves when the two requests do not cancel each other.
  always_comb begin
    w_set        = isLiveReg(i_setValid, i_setReg);
    w_clr        = isLiveReg(i_clrValid, i_clrReg);
    w_sameReg    = (i_setReg == i_clrReg);
    w_clrWasBusy = w_clr && r_busy[i_clrReg];
    w_inc        = w_set && !(w_clrWasBusy && w_sameReg);
    w_dec        = w_clrWasBusy && !(w_set && w_sameReg);

    w_busyNext = r_busy;
    if (w_clr) w_busyNext[i_clrReg] = 1'b0;
    if (w_set) w_busyNext[i_setReg] = 1'b1;

    w_countNext = r_count;
    case ({w_inc, w_dec})
      2'b10:   w_countNext = r_count + CNT_ONE;
      2'b01:   w_countNext = r_count - CNT_ONE;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busyNext;
      r_count <= w_countNext;
    end
  end

  assign o_busyA        = r_busy[i_queryA];
  assign o_busyB        = r_busy[i_queryB];
  assign o_busyIssue    = r_busy[i_queryIssue];
  assign o_pendingCount = r_count;

endmodule

// File: rtl/reg_file_scoreboard.sv
// 32-entry register file with write-first bypass on both read ports and a
// scoreboard that refuses a second reservation of a register still in flight.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadRegA,
  input  logic [ADDR_W-1:0] ReadRegB,
  output logic [DATA_W-1:0] ReadDataA,
  output logic [DATA_W-1:0] ReadDataB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              IssueStall,
  input  logic              WriteEn,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W:0]   PendingCount
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic w_writeHit;
  logic w_issueHit;
  logic w_issueAccept;
  logic w_bypassA;
  logic w_bypassB;
  logic w_busyRawA;
  logic w_busyRawB;
  logic w_busyIssue;

  // A writeback to the register being issued frees it this cycle, so the
  // new reservation may proceed instead of stalling on the old one.
  always_comb begin
    w_writeHit    = isLiveReg(WriteEn, WriteReg);
    w_issueHit    = isLiveReg(IssueValid, IssueReg);
    IssueStall    = w_issueHit && w_busyIssue &&
                    !(w_writeHit && (WriteReg == IssueReg));
    w_issueAccept = w_issueHit && !IssueStall;
  end

  scoreboard_bits u_scoreboard (
    .i_clk          (Clk),
    .i_reset        (Reset),
    .i_setValid     (w_issueAccept),
    .i_setReg       (IssueReg),
    .i_clrValid     (w_writeHit),
    .i_clrReg       (WriteReg),
    .i_queryA       (ReadRegA),
    .i_queryB       (ReadRegB),
    .i_queryIssue   (IssueReg),
    .o_busyA        (w_busyRawA),
    .o_busyB        (w_busyRawB),
    .o_busyIssue    (w_busyIssue),
    .o_pendingCount (PendingCount)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_writeHit) begin
      r_regs[WriteReg] <= WriteData;
    end
  end

  // Register 0 is hard-wired to zero; the bypass never matches it because
  // a write to index 0 is never live.
  always_comb begin
    w_bypassA = w_writeHit && (WriteReg == ReadRegA);
    w_bypassB = w_writeHit && (WriteReg == ReadRegB);

    ReadDataA = '0;
    if (w_bypassA)                   ReadDataA = WriteData;
    else if (ReadRegA != REG_ZERO)   ReadDataA = r_regs[ReadRegA];

    ReadDataB = '0;
    if (w_bypassB)                   ReadDataB = WriteData;
    else if (ReadRegB != REG_ZERO)   ReadDataB = r_regs[ReadRegB];

    BusyA = w_busyRawA && !w_bypassA && (ReadRegA != REG_ZERO);
    BusyB = w_busyRawB && !w_bypassB && (ReadRegB != REG_ZERO);
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed and randomized checks of reg_file_scoreboard against an
// array-based model of the register file and its busy set.
module tb_reg_file_scoreboard;
  import reg_file_scoreboard_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] ReadRegA, ReadRegB;
  logic [DATA_W-1:0] ReadDataA, ReadDataB;
  logic              BusyA, BusyB;
  logic              IssueValid;
  logic [ADDR_W-1:0] IssueReg;
  logic              IssueStall;
  logic              WriteEn;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W:0]   PendingCount;

  logic [DATA_W-1:0] mRegs [NUM_REGS];
  logic              mBusy [NUM_REGS];
  int                passCount = 0;
  int                checkCount = 0;

  reg_file_scoreboard dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .ReadRegA     (ReadRegA),
    .ReadRegB     (ReadRegB),
    .ReadDataA    (ReadDataA),
    .ReadDataB    (ReadDataB),
    .BusyA        (BusyA),
    .BusyB        (BusyB),
    .IssueValid   (IssueValid),
    .IssueReg     (IssueReg),
    .IssueStall   (IssueStall),
    .WriteEn      (WriteEn),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .PendingCount (PendingCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int busyTotal();
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) if (mBusy[i]) n++;
    return n;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected read result for one port: bypass of a live write wins, r0 is zero.
  task automatic expectRead(input logic [4:0] idx, output logic [31:0] data, output logic busy);
    if (WriteEn && WriteReg != 5'd0 && WriteReg == idx) begin
      data = WriteData; busy = 1'b0;
    end else if (idx == 5'd0) begin
      data = '0; busy = 1'b0;
    end else begin
      data = mRegs[idx]; busy = mBusy[idx];
    end
  endtask

  function automatic logic expectStall();
    return IssueValid && IssueReg != 5'd0 && mBusy[IssueReg] &&
           !(WriteEn && WriteReg == IssueReg);
  endfunction

  task automatic checkOutput(input string tag);
    logic [31:0] dA, dB;
    logic        bA, bB;
    expectRead(ReadRegA, dA, bA);
    expectRead(ReadRegB, dB, bB);
    compare({tag, ".dataA"}, ReadDataA, dA);
    compare({tag, ".dataB"}, ReadDataB, dB);
    compare({tag, ".busyA"}, {31'b0, BusyA}, {31'b0, bA});
    compare({tag, ".busyB"}, {31'b0, BusyB}, {31'b0, bB});
    compare({tag, ".stall"}, {31'b0, IssueStall}, {31'b0, expectStall()});
    compare({tag, ".count"}, 32'(PendingCount), 32'(busyTotal()));
  endtask

  task automatic updateModel();
    logic stall;
    stall = expectStall();
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mRegs[i] = '0; mBusy[i] = 1'b0;
      end
    end else begin
      if (WriteEn && WriteReg != 5'd0) begin
        mRegs[WriteReg] = WriteData;
        mBusy[WriteReg] = 1'b0;
      end
      if (IssueValid && IssueReg != 5'd0 && !stall) mBusy[IssueReg] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational
  // view mid-cycle, then advance the model across the rising edge.
  task automatic applyStimulus(input logic rst, input logic [4:0] ra, input logic [4:0] rb,
                               input logic iv, input logic [4:0] ir, input logic we,
                               input logic [4:0] wr, input logic [31:0] wd, input string tag);
    Reset = rst; ReadRegA = ra; ReadRegB = rb;
    IssueValid = iv; IssueReg = ir;
    WriteEn = we; WriteReg = wr; WriteData = wd;
    #1;
    checkOutput(tag);
    @(posedge Clk);
    updateModel();
    @(negedge Clk);
  endtask

  initial begin
    logic [4:0]  ra, rb, ir, wr;
    logic [31:0] wd;
    logic        rst, iv, we;

    for (int i = 0; i < NUM_REGS; i++) begin
      mRegs[i] = '0; mBusy[i] = 1'b0;
    end
    Reset = 1'b1; ReadRegA = '0; ReadRegB = '0; IssueValid = 1'b0; IssueReg = '0;
    WriteEn = 1'b0; WriteReg = '0; WriteData = '0;
    @(negedge Clk);
    @(negedge Clk);

    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(1'b0, 5'(i), 5'(31 - i), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, "reset_read");
    compare("reset.count", 32'(PendingCount), 32'd0);

    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, "bypass_r5");
    applyStimulus(1'b0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, "array_r5");
    compare("array_r5.const", ReadDataA, 32'hDEADBEEF);

    applyStimulus(1'b0, 5'd0, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, "issue_r8");
    compare("issue_r8.busyB", {31'b0, BusyB}, 32'd1);
    compare("issue_r8.count", 32'(PendingCount), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd8, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0, "reissue_r8");
    compare("reissue_r8.count", 32'(PendingCount), 32'd1);
    applyStimulus(1'b0, 5'd8, 5'd8, 1'b0, 5'd0, 1'b1, 5'd8, 32'h12, "write_r8");
    compare("write_r8.count", 32'(PendingCount), 32'd0);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, "r0_write_issue");
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, "r0_after");

    applyStimulus(1'b0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, "issue_r3");
    applyStimulus(1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 32'h55, "issue_write_r3");
    applyStimulus(1'b0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, "after_r3");
    compare("after_r3.busyA", {31'b0, BusyA}, 32'd1);
    compare("after_r3.count", 32'(PendingCount), 32'd1);

    for (int i = 1; i < NUM_REGS; i++)
      applyStimulus(i == 11, 5'(i), 5'd3, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0, "issue_seq_reset");
    for (int i = 0; i < NUM_REGS; i++) Reset = 1'b0;
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, "mid_reset");
    compare("mid_reset.count", 32'(PendingCount), 32'd0);
    for (int i = 0; i < NUM_REGS; i++)
      applyStimulus(1'b0, 5'(i), 5'(i), 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, "post_reset_read");

    for (int i = 1; i < NUM_REGS; i++)
      applyStimulus(1'b0, 5'(i), 5'd0, 1'b1, 5'(i), 1'b0, 5'd0, 32'd0, "fill_all");
    compare("fill_all.count", 32'(PendingCount), 32'd31);
    applyStimulus(1'b0, 5'd31, 5'd1, 1'b1, 5'd31, 1'b0, 5'd0, 32'd0, "full_stall");

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      we  = $urandom_range(0, 1) == 1;
      wr  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      iv  = $urandom_range(0, 1) == 1;
      ir  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 2) == 0) ? ir : 5'($urandom_range(0, 31));
      applyStimulus(rst, ra, rb, iv, ir, we, wr, wd, "random");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- 32-entry register file for the pipelined datapath, with a pending-write scoreboard.
- Sits at the consumer end of the destination-register select path:
  - decode presents the selected 5-bit destination (rt, rd or 31) as IssueReg.
  - writeback presents the same destination with result data.
- Provides two combinational read ports with write-first bypass.
- Tracks which registers have writes in flight, so the hazard logic can stall on a busy source or a WAW conflict.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of registers (2**ADDR_W)

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- ReadRegA  in  ADDR_W  read port A index
- ReadRegB  in  ADDR_W  read port B index
- ReadDataA  out  DATA_W  port A data (combinational)
- ReadDataB  out  DATA_W  port B data (combinational)
- BusyA  out  1  port A register has an outstanding write
- BusyB  out  1  port B register has an outstanding write
- IssueValid  in  1  decode requests reservation of IssueReg
- IssueReg  in  ADDR_W  destination being reserved
- IssueStall  out  1  reservation refused this cycle (WAW)
- WriteEn  in  1  writeback valid
- WriteReg  in  ADDR_W  writeback destination
- WriteData  in  DATA_W  writeback data
- PendingCount  out  ADDR_W+1  number of busy registers

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high. Ports are named Clk and Reset.
  - With Reset high at a rising edge: all registers are cleared to 0, all busy bits to 0, and PendingCount to 0.
  - Reset overrides any same-cycle write or issue.
  - After reset: ReadDataA/B = 0, BusyA/B = 0, IssueStall = 0.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues to index 0 are ignored: no state change and no stall.
- Write:
  - When WriteEn is high and WriteReg != 0, regs[WriteReg] <= WriteData at the edge.
  - The busy bit of WriteReg is cleared at the same edge, unless a same-cycle issue re-reserves it (see below).
  - A write to a non-busy register is legal: data is written and the busy bit stays 0.
- Read (combinational, zero latency):
  - If WriteEn is high, WriteReg == ReadRegX and ReadRegX != 0: ReadDataX = WriteData and BusyX = 0 (bypass).
  - Otherwise ReadDataX = regs[ReadRegX] and BusyX = busy[ReadRegX].
  - Ports A and B are fully independent and may address the same register.
- Issue:
  - IssueStall = IssueValid && IssueReg != 0 && busy[IssueReg] && !(WriteEn && WriteReg == IssueReg).
  - If IssueValid is high, IssueReg != 0 and IssueStall is low, busy[IssueReg] <= 1 at the edge.
  - Issue and writeback to the same register in the same cycle: the data is written, and busy ends at 1 (the new reservation wins).
  - A stalled issue has no effect; decode holds and retries.
- PendingCount:
  - Registered; always equals the popcount of the busy bits.
  - Next value = current + (issue accepted and not re-reserving a register cleared this cycle) − (write cleared a busy bit and no same-register issue).
  - Equivalently, it is +1/−1/0 per edge and never wraps; its maximum is 31.
- Latency:
  - Reads are combinational.
  - Written data and busy updates are visible through the register array from the cycle after the edge.
  - In the write cycle itself, written data is visible via the bypass.

Decomposition:
- Shared package:
  - DATA_W and ADDR_W.
  - Constant REG_ZERO = 0.
  - Constant REG_RA = 31, shared with the destination-select logic.
- One natural sub-module: scoreboard_bits.
  - Holds the 32 busy bits and PendingCount.
  - Inputs: issue and clear requests. Outputs: busy lookup per index.
  - Keeps the top level down to the storage array, bypass and read muxing.

Test Plan:
- Reset then read every index -> all ReadData = 0, Busy = 0, PendingCount = 0.
- Write 0xDEADBEEF to r5; same cycle read A = 5 -> ReadDataA = 0xDEADBEEF (bypass); next cycle it still reads 0xDEADBEEF from the array.
- Issue r8, then next cycle read B = 8 -> BusyB = 1, PendingCount = 1.
  - Then issue r8 again -> IssueStall = 1, PendingCount stays 1.
  - Then write r8 = 0x12 -> BusyB = 0 in that cycle, PendingCount = 0 after the edge.
- Write r0 = 0xFFFFFFFF and issue r0 -> ReadData for r0 = 0, no stall, PendingCount unchanged.
- With r3 busy, drive issue r3 and write r3 = 0x55 in the same cycle -> IssueStall = 0, r3 reads 0x55, busy[r3] = 1 afterwards, PendingCount unchanged.
- Issue r1..r31 on consecutive cycles, assert Reset mid-sequence (after r10) -> after the reset edge PendingCount = 0, all Busy = 0, all data = 0.
